// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle combinational ops plus a HI/LO unit that runs
// mult/multu/div/divu over a fixed latency and accepts mthi/mtlo writes.
module multicycle_alu #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned MUL_LAT = 5,
   parameter int unsigned DIV_LAT = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       ALUctr,
   input  logic [WIDTH-1:0] Op1,
   input  logic [WIDTH-1:0] Op2,
   output logic [WIDTH-1:0] ALUResult,
   output logic             Zero,
   output logic             busy,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_OR   = 4'b0010;
   localparam logic [3:0] OP_LUI  = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_SLT  = 4'b0101;
   localparam logic [3:0] OP_SLTU = 4'b0110;
   localparam logic [3:0] OP_MFHI = 4'b0111;
   localparam logic [3:0] OP_MFLO = 4'b1000;
   localparam logic [3:0] OP_MULT = 4'b1001;
   localparam logic [3:0] OP_MULU = 4'b1010;
   localparam logic [3:0] OP_DIV  = 4'b1011;
   localparam logic [3:0] OP_DIVU = 4'b1100;
   localparam logic [3:0] OP_MTHI = 4'b1101;
   localparam logic [3:0] OP_MTLO = 4'b1110;

   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, (WIDTH-1)'(0)};

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                   state, state_n;
   logic [CNT_W-1:0]         cnt, cnt_n;
   logic [WIDTH-1:0]         op_a, op_a_n;
   logic [WIDTH-1:0]         op_b, op_b_n;
   logic [3:0]               op_sel, op_sel_n;
   logic [WIDTH-1:0]         hi_q, hi_n;
   logic [WIDTH-1:0]         lo_q, lo_n;

   logic signed [2*WIDTH-1:0] a_sx, b_sx, prod_s;
   logic [2*WIDTH-1:0]        prod_u;
   logic                      div_zero, div_ovf;
   logic [WIDTH-1:0]          sdivisor, udivisor;
   logic [WIDTH-1:0]          squot, srem, uquot, urem;

   assign busy = (state == BUSY);
   assign HI   = hi_q;
   assign LO   = lo_q;
   assign Zero = (ALUResult == '0);

   // Single-cycle result path; multicycle and move codes read as zero
   always_comb begin
      ALUResult = '0;
      case (ALUctr)
         OP_ADD:  ALUResult = Op1 + Op2;
         OP_SUB:  ALUResult = Op1 - Op2;
         OP_OR:   ALUResult = Op1 | Op2;
         OP_LUI:  ALUResult = Op2 << (WIDTH / 2);
         OP_AND:  ALUResult = Op1 & Op2;
         OP_SLT:  ALUResult = WIDTH'($signed(Op1) < $signed(Op2));
         OP_SLTU: ALUResult = WIDTH'(Op1 < Op2);
         OP_MFHI: ALUResult = hi_q;
         OP_MFLO: ALUResult = lo_q;
         default: ALUResult = '0;
      endcase
   end

   // Full-width products of the captured operands
   assign a_sx   = $signed({{WIDTH{op_a[WIDTH-1]}}, op_a});
   assign b_sx   = $signed({{WIDTH{op_b[WIDTH-1]}}, op_b});
   assign prod_s = a_sx * b_sx;
   assign prod_u = {WIDTH'(0), op_a} * {WIDTH'(0), op_b};

   // Divisor forced to 1 on /0 (result discarded) and on MIN/-1, where
   // dividing by 1 yields exactly the wrapped quotient MIN with remainder 0
   assign div_zero = (op_b == '0);
   assign div_ovf  = (op_a == MIN_NEG) && (op_b == '1);
   assign sdivisor = (div_zero || div_ovf) ? WIDTH'(1) : op_b;
   assign udivisor = div_zero ? WIDTH'(1) : op_b;
   assign squot    = $signed(op_a) / $signed(sdivisor);
   assign srem     = $signed(op_a) % $signed(sdivisor);
   assign uquot    = op_a / udivisor;
   assign urem     = op_a % udivisor;

   // State, latency counter, captured operands and HI/LO registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         op_a   <= '0;
         op_b   <= '0;
         op_sel <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         op_a   <= op_a_n;
         op_b   <= op_b_n;
         op_sel <= op_sel_n;
         hi_q   <= hi_n;
         lo_q   <= lo_n;
      end
   end

   // Launch, count down and commit; requests while BUSY are dropped
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      op_a_n   = op_a;
      op_b_n   = op_b;
      op_sel_n = op_sel;
      hi_n     = hi_q;
      lo_n     = lo_q;
      case (state)
         IDLE: begin
            if (start) begin
               case (ALUctr)
                  OP_MULT, OP_MULU, OP_DIV, OP_DIVU: begin
                     state_n  = BUSY;
                     op_a_n   = Op1;
                     op_b_n   = Op2;
                     op_sel_n = ALUctr;
                     cnt_n    = (ALUctr == OP_MULT || ALUctr == OP_MULU) ?
                                CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
                  end
                  OP_MTHI: hi_n = Op1;
                  OP_MTLO: lo_n = Op1;
                  default: ;
               endcase
            end
         end
         BUSY: begin
            if (cnt <= CNT_W'(1)) begin
               state_n = IDLE;
               cnt_n   = '0;
               case (op_sel)
                  OP_MULT: {hi_n, lo_n} = prod_s;
                  OP_MULU: {hi_n, lo_n} = prod_u;
                  OP_DIV: begin
                     if (!div_zero) begin
                        lo_n = squot;
                        hi_n = srem;
                     end
                  end
                  OP_DIVU: begin
                     if (!div_zero) begin
                        lo_n = uquot;
                        hi_n = urem;
                     end
                  end
                  default: ;
               endcase
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: 32-bit default instance plus a
// 16-bit, single-cycle-latency instance.
module tb_multicycle_alu;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  ALUctr;
   logic [31:0] Op1, Op2;
   logic [31:0] ALUResult, HI, LO;
   logic        Zero, busy;

   logic        start_b;
   logic [3:0]  ALUctr_b;
   logic [15:0] Op1_b, Op2_b;
   logic [15:0] ALUResult_b, HI_b, LO_b;
   logic        Zero_b, busy_b;

   int n_checks = 0;
   int n_pass   = 0;
   int n;

   always #5 clk = ~clk;

   multicycle_alu dut (
      .clk(clk), .reset(reset), .start(start), .ALUctr(ALUctr),
      .Op1(Op1), .Op2(Op2), .ALUResult(ALUResult), .Zero(Zero),
      .busy(busy), .HI(HI), .LO(LO)
   );

   multicycle_alu #(.WIDTH(16), .MUL_LAT(1), .DIV_LAT(1)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .ALUctr(ALUctr_b),
      .Op1(Op1_b), .Op2(Op2_b), .ALUResult(ALUResult_b), .Zero(Zero_b),
      .busy(busy_b), .HI(HI_b), .LO(LO_b)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic comb(input string tag, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
      ALUctr = c; Op1 = a; Op2 = b;
      #1;
      check(tag, ALUResult, exp);
      check({tag, "_zero"}, Zero, exp == 32'h0);
   endtask

   // Counts cycles with busy high, bounded
   task automatic wait_idle(output int cycles);
      cycles = 0;
      while (busy && cycles < 200) begin
         cycles++;
         tick();
      end
   endtask

   // Launch at the next edge, scramble operands afterwards, count busy cycles
   task automatic run_op(input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, output int cycles);
      start = 1'b1; ALUctr = c; Op1 = a; Op2 = b;
      tick();
      start = 1'b0; Op1 = 32'h1357_9BDF; Op2 = 32'h0; ALUctr = 4'b0000;
      wait_idle(cycles);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; ALUctr = '0; Op1 = '0; Op2 = '0;
      start_b = 1'b0; ALUctr_b = '0; Op1_b = '0; Op2_b = '0;
      tick(); tick();
      reset = 1'b0;
      check("rst_busy", busy, 1'b0);
      check("rst_hi", HI, 32'h0);
      check("rst_lo", LO, 32'h0);

      comb("add",  4'b0000, 32'd7, 32'hFFFF_FFFD, 32'd4);
      comb("sub",  4'b0001, 32'd7, 32'hFFFF_FFFD, 32'd10);
      comb("or",   4'b0010, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      comb("and",  4'b0100, 32'd7, 32'hFFFF_FFFD, 32'd5);
      comb("slt",  4'b0101, 32'd7, 32'hFFFF_FFFD, 32'd0);
      comb("sltu", 4'b0110, 32'd7, 32'hFFFF_FFFD, 32'd1);
      comb("lui",  4'b0011, 32'd7, 32'h0000_1234, 32'h1234_0000);
      comb("addw", 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0);
      comb("zcode", 4'b1111, 32'd7, 32'd9, 32'd0);
      comb("mcode", 4'b1001, 32'd7, 32'd9, 32'd0);

      run_op(4'b1001, 32'hFFFF_FFFE, 32'd3, n);
      check("mult_lat", n, 5);
      check("mult_hi", HI, 32'hFFFF_FFFF);
      check("mult_lo", LO, 32'hFFFF_FFFA);

      run_op(4'b1010, 32'hFFFF_FFFE, 32'd3, n);
      check("multu_lat", n, 5);
      check("multu_hi", HI, 32'd2);
      check("multu_lo", LO, 32'hFFFF_FFFA);

      run_op(4'b1011, 32'hFFFF_FFF9, 32'd2, n);
      check("div_lat", n, 10);
      check("div_lo", LO, 32'hFFFF_FFFD);
      check("div_hi", HI, 32'hFFFF_FFFF);

      run_op(4'b1100, 32'd7, 32'd0, n);
      check("divz_lat", n, 10);
      check("divz_lo", LO, 32'hFFFF_FFFD);
      check("divz_hi", HI, 32'hFFFF_FFFF);

      run_op(4'b1011, 32'h8000_0000, 32'hFFFF_FFFF, n);
      check("divovf_lo", LO, 32'h8000_0000);
      check("divovf_hi", HI, 32'h0);

      run_op(4'b1011, 32'd7, 32'hFFFF_FFFE, n);
      check("divneg_lo", LO, 32'hFFFF_FFFD);
      check("divneg_hi", HI, 32'd1);

      run_op(4'b1100, 32'd100, 32'd7, n);
      check("divu_lo", LO, 32'd14);
      check("divu_hi", HI, 32'd2);

      // mthi / mtlo
      start = 1'b1; ALUctr = 4'b1101; Op1 = 32'hAA;
      tick();
      check("mthi_hi", HI, 32'hAA);
      check("mthi_busy", busy, 1'b0);
      ALUctr = 4'b1110; Op1 = 32'h55;
      tick();
      start = 1'b0;
      check("mtlo_lo", LO, 32'h55);
      check("mtlo_hi", HI, 32'hAA);

      // start with a plain ALU code has no sequential effect
      start = 1'b1; ALUctr = 4'b0000; Op1 = 32'h1; Op2 = 32'h2;
      tick();
      start = 1'b0;
      check("nop_busy", busy, 1'b0);
      check("nop_hi", HI, 32'hAA);

      // Requests while BUSY are ignored; mfhi/mflo see old values
      start = 1'b1; ALUctr = 4'b1001; Op1 = 32'd2; Op2 = 32'd3;
      tick();
      Op1 = 32'd100; Op2 = 32'd100;
      tick();
      ALUctr = 4'b1110; Op1 = 32'h77;
      tick();
      start = 1'b0;
      check("ign_hi", HI, 32'hAA);
      check("ign_lo", LO, 32'h55);
      ALUctr = 4'b0111; #1;
      check("mfhi_busy", ALUResult, 32'hAA);
      ALUctr = 4'b1000; #1;
      check("mflo_busy", ALUResult, 32'h55);
      wait_idle(n);
      check("ign_rest", n, 3);
      check("ign_mhi", HI, 32'd0);
      check("ign_mlo", LO, 32'd6);

      // Reset mid-divide aborts, then a mult on the next edge completes
      start = 1'b1; ALUctr = 4'b1011; Op1 = 32'd100; Op2 = 32'd7;
      tick();
      start = 1'b0;
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_hi", HI, 32'h0);
      check("abort_lo", LO, 32'h0);
      run_op(4'b1001, 32'hFFFF_FFFE, 32'd3, n);
      check("post_lat", n, 5);
      check("post_hi", HI, 32'hFFFF_FFFF);
      check("post_lo", LO, 32'hFFFF_FFFA);

      // Reset beats a simultaneous mthi
      reset = 1'b1; start = 1'b1; ALUctr = 4'b1101; Op1 = 32'h33;
      tick();
      reset = 1'b0; start = 1'b0;
      check("rstpri_hi", HI, 32'h0);

      // 16-bit instance with single-cycle latency
      start_b = 1'b1; ALUctr_b = 4'b1001; Op1_b = 16'h8000; Op2_b = 16'h8000;
      tick();
      start_b = 1'b0; Op1_b = 16'h0;
      check("w16_busy", busy_b, 1'b1);
      tick();
      check("w16_idle", busy_b, 1'b0);
      check("w16_hi", HI_b, 16'h4000);
      check("w16_lo", LO_b, 16'h0);
      start_b = 1'b1; ALUctr_b = 4'b1011; Op1_b = 16'hFFF9; Op2_b = 16'h2;
      tick();
      start_b = 1'b0;
      tick();
      check("w16_div_lo", LO_b, 16'hFFFD);
      check("w16_div_hi", HI_b, 16'hFFFF);
      ALUctr_b = 4'b0011; Op2_b = 16'h00AB; #1;
      check("w16_lui", ALUResult_b, 16'hAB00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; SHALL be even and at least 8.
REQ-002 Parameter MUL_LAT, default 5, multiply latency in cycles; SHALL be at least 1.
REQ-003 Parameter DIV_LAT, default 10, divide latency in cycles; SHALL be at least 1.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  qualifies ALUctr as a request to launch a multicycle op or an mthi/mtlo write.
REQ-007 ALUctr  input  4  operation select (encoding in REQ-012).
REQ-008 Op1  input  WIDTH  first operand (rs).
REQ-009 Op2  input  WIDTH  second operand (rt/imm).
REQ-010 ALUResult, Zero, busy  output  WIDTH, 1, 1  combinational result; Zero = (ALUResult == 0); busy = multicycle op in flight.
REQ-011 HI, LO  output  WIDTH each  registered HI/LO contents.

Function
REQ-012 ALUctr encoding (combinational ALUResult): 0000 Op1+Op2; 0001 Op1-Op2; 0010 Op1|Op2; 0011 Op2<<(WIDTH/2); 0100 Op1&Op2; 0101 signed Op1<Op2 ? 1 : 0; 0110 unsigned Op1<Op2 ? 1 : 0; 0111 HI; 1000 LO; 1001 mult; 1010 multu; 1011 div; 1100 divu; 1101 mthi; 1110 mtlo; 1111 zero.
REQ-013 Add/sub SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-014 For codes 1001-1110 and 1111, ALUResult SHALL be 0.
REQ-015 ALUResult SHALL never be latched or undefined for any code; no inferred latches.
REQ-016 FSM states IDLE and BUSY; busy = (state == BUSY).
REQ-017 IDLE -> BUSY at edge k when start=1 and ALUctr is 1001-1100; Op1, Op2 and op SHALL be captured at edge k; a down-counter SHALL load MUL_LAT (mult/multu) or DIV_LAT (div/divu).
REQ-018 busy SHALL be high for exactly the latency count of cycles, from after edge k through edge k+LAT; BUSY -> IDLE at edge k+LAT.
REQ-019 HI/LO SHALL update at edge k+LAT only, using captured operands; later Op1/Op2 changes SHALL have no effect.
REQ-020 mult/multu: {HI,LO} = full 2*WIDTH-bit signed/unsigned product.
REQ-021 div/divu: LO = quotient, HI = remainder; signed division truncates toward zero, remainder takes the dividend's sign.
REQ-022 Divide by zero: full latency elapses; HI and LO SHALL remain unchanged.
REQ-023 Signed div of most-negative by -1: LO = most-negative value, HI = 0.
REQ-024 start=1 with mthi (mtlo) in IDLE: HI (LO) = Op1 at that edge; busy stays low.
REQ-025 start=1 with any code while BUSY SHALL be ignored: no restart, no HI/LO write.
REQ-026 start=1 with codes 0000-1000 or 1111 SHALL have no sequential effect.
REQ-027 While BUSY, reads of HI/LO (0111/1000) SHALL return the pre-operation values; stalling is the consumer's responsibility.
REQ-028 A new start SHALL be accepted at the first edge with busy low, giving back-to-back ops with one IDLE cycle between BUSY periods.

Reset
REQ-029 reset=1 at an edge SHALL force state IDLE, busy=0, counter=0, HI=0, LO=0, and clear the captured operands to 0.
REQ-030 Reset SHALL take priority over start and over completion on the same edge; an in-flight op SHALL be aborted with no HI/LO write.
REQ-031 The first start SHALL be accepted on the first edge after reset deasserts.

Verification
REQ-032 WIDTH=32: Op1=7, Op2=0xFFFFFFFD, ALUctr 0000 -> ALUResult=4, Zero=0; 0101 -> 0; 0110 -> 1; 0011 with Op2=0x1234 -> 0x12340000.
REQ-033 mult of Op1=0xFFFFFFFE, Op2=3 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu of the same operands -> HI=2, LO=0xFFFFFFFA.
REQ-034 div of Op1=-7, Op2=2 -> busy high 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu of Op1=7, Op2=0 -> HI/LO unchanged.
REQ-035 mthi 0xAA, then start mult in cycle 2 of BUSY plus an mtlo -> both ignored; mfhi during BUSY returns 0xAA.
REQ-036 reset asserted at cycle 3 of a div -> busy=0, HI=LO=0 next cycle; a mult started on the following edge completes normally.
REQ-037 Parameter sweep WIDTH=16, MUL_LAT=1, DIV_LAT=1: mult 0x8000*0x8000 -> HI=0x4000, LO=0 after 1 busy cycle.
